// File: rtl/shift_stack_ram_if.sv
// Operation/response bundle for shift_stack_ram.
// The master issues one op per cycle; the slave answers with registered data and status.
interface shift_stack_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  en;
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] di;
    logic [DATA_WIDTH-1:0] dout;
    logic                  do_valid;
    logic                  err;
    logic                  dropped;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;

    modport master (
        output en, op, addr, di,
        input  dout, do_valid, err, dropped, count, full, empty
    );

    modport slave (
        input  en, op, addr, di,
        output dout, do_valid, err, dropped, count, full, empty
    );
endinterface

// File: rtl/shift_stack_ram.sv
// Shift-addressed history buffer: entry 0 is the newest word, older words at higher indices.
// Supports push, pop, addressed read and addressed overwrite, with occupancy and error pulses.
module shift_stack_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic              clock,
    input logic              reset,
    shift_stack_ram_if.slave bus
);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem, mem_nxt;
    logic [ADDR_WIDTH:0]              count, count_nxt;
    logic [DATA_WIDTH-1:0]            dout, dout_nxt;
    logic                             do_valid, do_valid_nxt;
    logic                             err, err_nxt;
    logic                             dropped, dropped_nxt;
    logic                             addr_ok;

    // count never exceeds DEPTH, so this also rejects addr >= DEPTH
    assign addr_ok = {1'b0, bus.addr} < count;

    always_comb begin
        mem_nxt      = mem;
        count_nxt    = count;
        dout_nxt     = dout;
        do_valid_nxt = 1'b0;
        err_nxt      = 1'b0;
        dropped_nxt  = 1'b0;
        if (bus.en) begin
            case (bus.op)
                OP_READ: begin
                    if (addr_ok) begin
                        dout_nxt     = mem[bus.addr];
                        do_valid_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                OP_PUSH: begin
                    mem_nxt      = {mem[DEPTH-2:0], bus.di};
                    dout_nxt     = bus.di;
                    do_valid_nxt = 1'b1;
                    if (count == FULL_CNT) dropped_nxt = 1'b1;
                    else                   count_nxt   = count + 1'b1;
                end
                OP_WRITE: begin
                    if (addr_ok) mem_nxt[bus.addr] = bus.di;
                    else         err_nxt = 1'b1;
                end
                default: begin
                    if (count != '0) begin
                        // zero-fill the top so entries at index >= count stay cleared
                        dout_nxt     = mem[0];
                        do_valid_nxt = 1'b1;
                        mem_nxt      = {{DATA_WIDTH{1'b0}}, mem[DEPTH-1:1]};
                        count_nxt    = count - 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem      <= '0;
            count    <= '0;
            dout     <= '0;
            do_valid <= 1'b0;
            err      <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            mem      <= mem_nxt;
            count    <= count_nxt;
            dout     <= dout_nxt;
            do_valid <= do_valid_nxt;
            err      <= err_nxt;
            dropped  <= dropped_nxt;
        end
    end

    assign bus.dout     = dout;
    assign bus.do_valid = do_valid;
    assign bus.err      = err;
    assign bus.dropped  = dropped;
    assign bus.count    = count;
    assign bus.full     = (count == FULL_CNT);
    assign bus.empty    = (count == '0);
endmodule

// File: tb/tb_shift_stack_ram.sv
// Scoreboard bench for shift_stack_ram: a queue-based history model predicts every cycle's response,
// a monitor process compares the DUT outputs against the predictions.
module tb_shift_stack_ram;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    shift_stack_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    shift_stack_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] dout;
        logic          dv;
        logic          er;
        logic          dr;
        int            cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mdl[$];     // mdl[0] is the newest word
    logic [DW-1:0] mdo = '0;
    int            total = 0;
    int            bad   = 0;
    int            ncyc  = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL cyc%0d %s: got %0h want %0h", ncyc, name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a response that must match the oldest prediction
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            ncyc++;
            chk("do",       int'(bus.dout),     int'(e.dout));
            chk("do_valid", int'(bus.do_valid), int'(e.dv));
            chk("err",      int'(bus.err),      int'(e.er));
            chk("dropped",  int'(bus.dropped),  int'(e.dr));
            chk("count",    int'(bus.count),    e.cnt);
            chk("full",     int'(bus.full),     int'(e.cnt == DEPTH));
            chk("empty",    int'(bus.empty),    int'(e.cnt == 0));
        end
    end

    // Drive one cycle, advance the model, and hand the prediction to the monitor after the edge
    task automatic drive(input logic rst_v, input logic en_v, input logic [1:0] op_v,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        int   ai;
        @(negedge clock);
        reset  = rst_v;
        bus.en = en_v;
        bus.op = op_v;
        bus.addr = a;
        bus.di = d;
        ai = int'(a);
        e.dv = 1'b0; e.er = 1'b0; e.dr = 1'b0;
        if (!rst_v) begin
            mdl.delete();
            mdo = '0;
        end else if (en_v) begin
            case (op_v)
                2'b00: if (ai < mdl.size()) begin mdo = mdl[ai]; e.dv = 1'b1; end
                       else e.er = 1'b1;
                2'b01: begin
                    mdl.push_front(d);
                    mdo = d;
                    e.dv = 1'b1;
                    if (mdl.size() > DEPTH) begin
                        void'(mdl.pop_back());
                        e.dr = 1'b1;
                    end
                end
                2'b10: if (ai < mdl.size()) mdl[ai] = d;
                       else e.er = 1'b1;
                default: if (mdl.size() > 0) begin mdo = mdl.pop_front(); e.dv = 1'b1; end
                         else e.er = 1'b1;
            endcase
        end
        e.dout = mdo;
        e.cnt  = mdl.size();
        @(posedge clock);
        exp_q.push_back(e);
    endtask

    task automatic op(input logic [1:0] o, input int a, input int d);
        drive(1'b1, 1'b1, o, AW'(a), DW'(d));
    endtask

    initial begin
        bus.en = 1'b0; bus.op = 2'b00; bus.addr = '0; bus.di = '0;
        drive(1'b0, 1'b0, 2'b00, '0, '0);
        drive(1'b0, 1'b0, 2'b00, '0, '0);

        op(2'b11, 0, 0);                       // pop on empty
        op(2'b01, 0, 8'h11); op(2'b01, 0, 8'h22); op(2'b01, 0, 8'h33);
        for (int i = 0; i < 4; i++) op(2'b00, i, 0);   // addr 3 is out of range
        op(2'b10, 1, 8'hAA); op(2'b00, 1, 0);
        op(2'b10, 5, 8'h5C); op(2'b00, 1, 0); op(2'b00, 2, 0);
        for (int i = 0; i < 4; i++) op(2'b11, 0, 0);   // last pop hits empty

        for (int i = 1; i <= 9; i++) op(2'b01, 0, i);
        op(2'b00, 7, 0); op(2'b00, 0, 0);

        drive(1'b0, 1'b1, 2'b01, '0, 8'hEE);   // reset wins over a push into a full array
        op(2'b00, 0, 0);
        op(2'b01, 0, 8'h42);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 2'($urandom_range(3)), AW'($urandom), DW'($urandom));
        op(2'b00, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] o;
            o = 2'($urandom_range(3));
            if (o == 2'b11 && $urandom_range(1) == 1) o = 2'b01;   // bias toward filling up
            drive(($urandom_range(39) != 0), ($urandom_range(7) != 0), o,
                  AW'($urandom), DW'($urandom));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
